// File: rtl/riscv_crypto_sbox_aes_pipe_if.sv
// Handshake and data bundle for the pipelined AES S-box unit.
// The master side is the producer/consumer pair around the unit; the slave
// side is the S-box pipeline itself.
interface riscv_crypto_sbox_aes_pipe_if #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [8*LANES-1:0]   in_data;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_mode;
  logic                 busy;

  modport master (
    output flush, in_valid, in_mode, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_mode, busy
  );

  modport slave (
    input  flush, in_valid, in_mode, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_mode, busy
  );
endinterface

// File: rtl/riscv_crypto_sbox_aes_pipe.sv
// Two-stage pipelined multi-lane AES S-box (forward / inverse).
// Each lane uses the Boyar-Peralta decomposition: a top linear layer
// (8 -> 21 bits) registered in stage 1, then the shared GF(2^8) inversion
// middle layer (21 -> 18 bits) and a bottom linear layer registered in
// stage 2. The inverse direction reuses the forward top/bottom layers wrapped
// by the inverse AES affine map, so one middle layer serves both modes.
module riscv_crypto_sbox_aes_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input logic                      clk,
  input logic                      reset,
  riscv_crypto_sbox_aes_pipe_if.slave bus
);

  // Inverse AES affine transform (constant 0x05 folded in).
  function automatic logic [7:0] inv_affine(input logic [7:0] y);
    logic [7:0] b;
    b[0] = y[2] ^ y[5] ^ y[7] ^ 1'b1;
    b[1] = y[3] ^ y[6] ^ y[0];
    b[2] = y[4] ^ y[7] ^ y[1] ^ 1'b1;
    b[3] = y[5] ^ y[0] ^ y[2];
    b[4] = y[6] ^ y[1] ^ y[3];
    b[5] = y[7] ^ y[2] ^ y[4];
    b[6] = y[0] ^ y[3] ^ y[5];
    b[7] = y[1] ^ y[4] ^ y[6];
    return b;
  endfunction

  // Forward top linear layer; u0 is the byte MSB. u7 is not carried
  // separately because it equals t8 ^ t6.
  function automatic logic [20:0] top_fwd(input logic [7:0] x);
    logic u0, u1, u2, u3, u4, u5, u6, u7;
    logic t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14;
    logic t15, t16, t17, t18, t19, t20, t21, t22, t23, t24, t25, t26, t27;
    {u0, u1, u2, u3, u4, u5, u6, u7} = x;
    t1  = u0 ^ u3;   t2  = u0 ^ u5;   t3  = u0 ^ u6;   t4  = u3 ^ u5;
    t5  = u4 ^ u6;   t6  = t1 ^ t5;   t7  = u1 ^ u2;   t8  = u7 ^ t6;
    t9  = u7 ^ t7;   t10 = t6 ^ t7;   t11 = u1 ^ u5;   t12 = u2 ^ u5;
    t13 = t3 ^ t4;   t14 = t6 ^ t11;  t15 = t5 ^ t11;  t16 = t5 ^ t12;
    t17 = t9 ^ t16;  t18 = u3 ^ u7;   t19 = t7 ^ t18;  t20 = t1 ^ t19;
    t21 = u6 ^ u7;   t22 = t7 ^ t21;  t23 = t2 ^ t22;  t24 = t2 ^ t10;
    t25 = t20 ^ t17; t26 = t3 ^ t16;  t27 = t1 ^ t12;
    return {t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19,
            t20, t22, t23, t24, t25, t26, t27};
  endfunction

  // Shared middle layer: GF(2^8) inversion in tower-field form.
  function automatic logic [17:0] mid_layer(input logic [20:0] t);
    logic t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19;
    logic t20, t22, t23, t24, t25, t26, t27, u7;
    logic m1, m2, m3, m4, m5, m6, m7, m8, m9, m10, m11, m12, m13, m14, m15;
    logic m16, m17, m18, m19, m20, m21, m22, m23, m24, m25, m26, m27, m28;
    logic m29, m30, m31, m32, m33, m34, m35, m36, m37, m38, m39, m40, m41;
    logic m42, m43, m44, m45, m46, m47, m48, m49, m50, m51, m52, m53, m54;
    logic m55, m56, m57, m58, m59, m60, m61, m62, m63;
    {t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19,
     t20, t22, t23, t24, t25, t26, t27} = t;
    u7  = t8 ^ t6;
    m1  = t13 & t6;   m2  = t23 & t8;   m3  = t14 ^ m1;   m4  = t19 & u7;
    m5  = m4 ^ m1;    m6  = t3 & t16;   m7  = t22 & t9;   m8  = t26 ^ m6;
    m9  = t20 & t17;  m10 = m9 ^ m6;    m11 = t1 & t15;   m12 = t4 & t27;
    m13 = m12 ^ m11;  m14 = t2 & t10;   m15 = m14 ^ m11;  m16 = m3 ^ m2;
    m17 = m5 ^ t24;   m18 = m8 ^ m7;    m19 = m10 ^ m15;  m20 = m16 ^ m13;
    m21 = m17 ^ m15;  m22 = m18 ^ m13;  m23 = m19 ^ t25;  m24 = m22 ^ m23;
    m25 = m22 & m20;  m26 = m21 ^ m25;  m27 = m20 ^ m21;  m28 = m23 ^ m25;
    m29 = m28 & m27;  m30 = m26 & m24;  m31 = m20 & m23;  m32 = m27 & m31;
    m33 = m27 ^ m25;  m34 = m21 & m22;  m35 = m24 & m34;  m36 = m24 ^ m25;
    m37 = m21 ^ m29;  m38 = m32 ^ m33;  m39 = m23 ^ m30;  m40 = m35 ^ m36;
    m41 = m38 ^ m40;  m42 = m37 ^ m39;  m43 = m37 ^ m38;  m44 = m39 ^ m40;
    m45 = m42 ^ m41;
    m46 = m44 & t6;   m47 = m40 & t8;   m48 = m39 & u7;   m49 = m43 & t16;
    m50 = m38 & t9;   m51 = m37 & t17;  m52 = m42 & t15;  m53 = m45 & t27;
    m54 = m41 & t10;  m55 = m44 & t13;  m56 = m40 & t23;  m57 = m39 & t19;
    m58 = m43 & t3;   m59 = m38 & t22;  m60 = m37 & t20;  m61 = m42 & t1;
    m62 = m45 & t4;   m63 = m41 & t2;
    return {m46, m47, m48, m49, m50, m51, m52, m53, m54, m55, m56, m57, m58,
            m59, m60, m61, m62, m63};
  endfunction

  // Forward bottom linear layer including the 0x63 affine constant.
  function automatic logic [7:0] bot_fwd(input logic [17:0] m);
    logic m46, m47, m48, m49, m50, m51, m52, m53, m54, m55, m56, m57, m58;
    logic m59, m60, m61, m62, m63;
    logic l0, l1, l2, l3, l4, l5, l6, l7, l8, l9, l10, l11, l12, l13, l14;
    logic l15, l16, l17, l18, l19, l20, l21, l22, l23, l24, l25, l26, l27;
    logic l28, l29;
    logic s0, s1, s2, s3, s4, s5, s6, s7;
    {m46, m47, m48, m49, m50, m51, m52, m53, m54, m55, m56, m57, m58,
     m59, m60, m61, m62, m63} = m;
    l0  = m61 ^ m62;  l1  = m50 ^ m56;  l2  = m46 ^ m48;  l3  = m47 ^ m55;
    l4  = m54 ^ m58;  l5  = m49 ^ m61;  l6  = m62 ^ l5;   l7  = m46 ^ l3;
    l8  = m51 ^ m59;  l9  = m52 ^ m53;  l10 = m53 ^ l4;   l11 = m60 ^ l2;
    l12 = m48 ^ m51;  l13 = m50 ^ l0;   l14 = m52 ^ m61;  l15 = m55 ^ l1;
    l16 = m56 ^ l0;   l17 = m57 ^ l1;   l18 = m58 ^ l8;   l19 = m63 ^ l4;
    l20 = l0 ^ l1;    l21 = l1 ^ l7;    l22 = l3 ^ l12;   l23 = l18 ^ l2;
    l24 = l15 ^ l9;   l25 = l6 ^ l10;   l26 = l7 ^ l9;    l27 = l8 ^ l10;
    l28 = l11 ^ l14;  l29 = l11 ^ l17;
    s0 = l6 ^ l24;         s1 = ~(l16 ^ l26);  s2 = ~(l19 ^ l28);
    s3 = l6 ^ l21;         s4 = l20 ^ l22;     s5 = l25 ^ l29;
    s6 = ~(l13 ^ l27);     s7 = ~(l6 ^ l23);
    return {s0, s1, s2, s3, s4, s5, s6, s7};
  endfunction

  logic                    s1_valid_r;
  logic                    s1_mode_r;
  logic [TAG_W-1:0]        s1_tag_r;
  logic [LANES-1:0][20:0]  s1_top_r;
  logic                    out_valid_r;
  logic                    out_mode_r;
  logic [TAG_W-1:0]        out_tag_r;
  logic [8*LANES-1:0]      out_data_r;

  logic [LANES-1:0][20:0]  top_in_s;
  logic [LANES-1:0][17:0]  mid_s;
  logic [LANES-1:0][7:0]   byte_s;
  logic                    s2_adv_s;
  logic                    s1_adv_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    s2_load_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign top_in_s[g] = bus.in_mode ? top_fwd(inv_affine(bus.in_data[8*g +: 8]))
                                     : top_fwd(bus.in_data[8*g +: 8]);
    assign mid_s[g]    = mid_layer(s1_top_r[g]);
    assign byte_s[g]   = s1_mode_r ? inv_affine(bot_fwd(mid_s[g]))
                                   : bot_fwd(mid_s[g]);
  end

  // Ready chain: each stage may advance when the stage after it frees up.
  always_comb begin
    s2_adv_s   = !out_valid_r || bus.out_ready;
    s1_adv_s   = !s1_valid_r || s2_adv_s;
    in_ready_s = s1_adv_s && !bus.flush;
    accept_s   = bus.in_valid && in_ready_s;
    s2_load_s  = s2_adv_s && s1_valid_r && !bus.flush;
  end

  // Stage valid flags; flush and reset drop everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.flush) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (s1_adv_s) s1_valid_r <= accept_s;
      if (s2_adv_s) out_valid_r <= s1_valid_r;
    end
  end

  // Stage 1 data: only captured on an accepted transaction to avoid toggling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_top_r  <= {(21*LANES){1'b0}};
      s1_mode_r <= 1'b0;
      s1_tag_r  <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      s1_top_r  <= top_in_s;
      s1_mode_r <= bus.in_mode;
      s1_tag_r  <= bus.in_tag;
    end
  end

  // Stage 2 data: result bytes held stable while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r <= {(8*LANES){1'b0}};
      out_tag_r  <= {TAG_W{1'b0}};
      out_mode_r <= 1'b0;
    end else if (s2_load_s) begin
      out_data_r <= byte_s;
      out_tag_r  <= s1_tag_r;
      out_mode_r <= s1_mode_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_tag   = out_tag_r;
  assign bus.out_mode  = out_mode_r;
  assign bus.busy      = s1_valid_r || out_valid_r;

endmodule

// File: tb/tb_riscv_crypto_sbox_aes_pipe.sv
// Self-checking bench for riscv_crypto_sbox_aes_pipe (LANES=4, TAG_W=4).
// Hand-computed vectors plus an S-box table scoreboard for streamed traffic.
module tb_riscv_crypto_sbox_aes_pipe;
  localparam int LANES = 4;
  localparam int TAG_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  riscv_crypto_sbox_aes_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

  riscv_crypto_sbox_aes_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox_t [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] isbox_t [0:255];

  typedef struct { logic mode; logic [31:0] din; logic [31:0] dout; } vec_t;
  typedef struct { logic mode; logic [31:0] data; logic [3:0] tag; } exp_t;

  vec_t vecs [7];
  exp_t sb [$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] ref_fn(input logic m, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = m ? isbox_t[d[8*i +: 8]] : sbox_t[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [31:0] d, input logic [3:0] t);
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    bus.in_tag   = t;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      got = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for 64 cycles, want 1");
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 50 && sb.size() != 0; c++) tick();
    tick();
    check({name, "_sb_empty"}, sb.size(), 32'd0);
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Scoreboard: record accepted inputs, compare every consumed result in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_extra: got result tag %0h, want no result", bus.out_tag);
        end else begin
          mon_e = sb.pop_front();
          check("sb_data", bus.out_data, mon_e.data);
          check("sb_tag", {28'd0, bus.out_tag}, {28'd0, mon_e.tag});
          check("sb_mode", {31'd0, bus.out_mode}, {31'd0, mon_e.mode});
        end
      end
      if (bus.flush) sb.delete();
      else if (bus.in_valid && bus.in_ready)
        sb.push_back('{bus.in_mode, ref_fn(bus.in_mode, bus.in_data), bus.in_tag});
    end
  end

  logic [31:0] d;
  logic [31:0] bp_d [5];
  int unsigned tagc;

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_mode = 1'b0;
    bus.in_data = 32'd0; bus.in_tag = 4'd0; bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

    vecs[0] = '{1'b0, 32'hFF530100, 32'h16ED7C63};
    vecs[1] = '{1'b1, 32'h0016ED63, 32'h52FF5300};
    vecs[2] = '{1'b0, 32'h00000000, 32'h63636363};
    vecs[3] = '{1'b1, 32'h63636363, 32'h00000000};
    vecs[4] = '{1'b0, 32'h80011053, 32'hCD7CCAED};
    vecs[5] = '{1'b1, 32'hCD7CCAED, 32'h80011053};
    vecs[6] = '{1'b0, 32'h3C9A5E07, 32'hEBB858C5};

    // Reset state, released between clock edges
    #22 reset = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
    check("rst_out_mode", {31'd0, bus.out_mode}, 32'd0);
    tick();

    // Directed vectors: latency 2 edges, busy clears after consumption
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = vecs[i].mode;
      bus.in_data  = vecs[i].din;
      bus.in_tag   = 4'(i);
      tick();
      bus.in_valid = 1'b0;
      check("vec_early_valid", {31'd0, bus.out_valid}, 32'd0);
      check("vec_busy_s1", {31'd0, bus.busy}, 32'd1);
      tick();
      check("vec_valid", {31'd0, bus.out_valid}, 32'd1);
      check("vec_data", bus.out_data, vecs[i].dout);
      check("vec_tag", {28'd0, bus.out_tag}, 32'(i));
      check("vec_mode", {31'd0, bus.out_mode}, {31'd0, vecs[i].mode});
      tick();
      check("vec_busy_done", {31'd0, bus.busy}, 32'd0);
    end

    // Exhaustive forward/inverse round trip, mode alternating every cycle
    for (int x = 0; x < 256; x++) begin
      d = {8'(x + 3), 8'(x + 2), 8'(x + 1), 8'(x)};
      send(1'b0, d, 4'(x));
      send(1'b1, ref_fn(1'b0, d), 4'(x));
    end
    drain("sweep");

    // Back-pressure: two absorbed, third refused, output held stable
    for (int t = 0; t < 5; t++) bp_d[t] = 32'h10203040 + 32'(t * 32'h01010101);
    bus.out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_data = bp_d[t]; bus.in_tag = 4'(t);
      @(negedge clk);
      check("bp_accept", {31'd0, bus.in_ready}, 32'd1);
      tick();
    end
    bus.in_data = bp_d[2]; bus.in_tag = 4'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_stall_data", bus.out_data, ref_fn(1'b0, bp_d[0]));
      check("bp_stall_tag", {28'd0, bus.out_tag}, 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_ready_rise", {31'd0, bus.in_ready}, 32'd1);
    for (int t = 2; t < 5; t++) send(1'b0, bp_d[t], 4'(t));
    drain("bp");

    // Flush with both stages full and an input presented
    bus.out_ready = 1'b0;
    send(1'b0, 32'hA1B2C3D4, 4'd5);
    send(1'b1, 32'h11223344, 4'd6);
    bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_data = 32'h55667788; bus.in_tag = 4'd7;
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_busy", {31'd0, bus.busy}, 32'd0);
    bus.out_ready = 1'b1;
    send(1'b0, vecs[0].din, 4'd8);
    tick();
    check("fl_next_valid", {31'd0, bus.out_valid}, 32'd1);
    check("fl_next_data", bus.out_data, vecs[0].dout);
    check("fl_next_tag", {28'd0, bus.out_tag}, 32'd8);
    drain("fl");

    // Asynchronous reset pulse with two transactions in flight
    bus.out_ready = 1'b0;
    send(1'b0, 32'hDEADBEEF, 4'd9);
    send(1'b0, 32'h01234567, 4'd10);
    #1 reset = 1'b1;
    #1;
    check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_out_data", bus.out_data, 32'd0);
    check("ar_busy", {31'd0, bus.busy}, 32'd0);
    #1 reset = 1'b0;
    sb.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("ar_no_stale", {31'd0, bus.out_valid}, 32'd0);
    end

    // Random valid/ready/flush traffic against the table scoreboard
    tagc = 0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_mode   = 1'($urandom_range(0, 1));
      bus.in_data   = $urandom();
      bus.in_tag    = tagc[3:0];
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) tagc++;
      tick();
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
